// File: rtl/serial_frame_rx_if.sv
// Handshake bundle for serial_frame_rx: serial input side plus the
// parallel word and status pulses going back to the consumer.
interface serial_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic              sdin;
  logic              en;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  // Producer / consumer side: drives the bit stream, watches the results
  modport master (
    output sdin, en,
    input  data_out, data_valid, parity_err, frame_err, busy
  );

  // Receiver side
  modport slave (
    input  sdin, en,
    output data_out, data_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional
// parity bit, stop bit. Good words are presented with a one-cycle valid
// pulse; parity and framing errors get their own one-cycle pulses.
module serial_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_frame_rx_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HI
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        count_q, count_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_q, par_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              parity_ok;

  // Parity verdict on the captured word; always good when no parity bit is sent
  assign parity_ok = (PARITY_EN == 0) || ((^shift_q ^ par_q) == (PARITY_ODD != 0));

  // Next-state logic: everything advances only on strobed edges, pulses default low
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    if (bus.en) begin
      unique case (state_q)
        S_IDLE: begin
          if (!bus.sdin) begin
            state_d = S_DATA;
            count_d = '0;
          end
        end
        S_DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (count_q == 5'(i)) shift_d[i] = bus.sdin;
          end
          if (count_q == 5'(DATA_W - 1)) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            count_d = count_q + 5'd1;
          end
        end
        S_PARITY: begin
          par_d   = bus.sdin;
          state_d = S_STOP;
        end
        S_STOP: begin
          if (bus.sdin) begin
            state_d = S_IDLE;
            if (parity_ok) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              perr_d = 1'b1;
            end
          end else begin
            // Framing error wins over any parity problem in the same frame
            ferr_d  = 1'b1;
            state_d = S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          // Line must return high before a new start bit is trusted
          if (bus.sdin) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule
